// File: rtl/id_issue_buffer_pkg.sv
// Shared types and sizing helpers for the ID/issue ring buffer.
// Sizing localparams below describe the default build (Depth=4, DataWidth=128).
package id_issue_buffer_pkg;

  localparam int unsigned DefDataWidth = 128;
  localparam int unsigned DefDepth     = 4;
  localparam int unsigned InstrWidth   = 32;
  localparam int unsigned PtrWidth     = $clog2(DefDepth);
  localparam int unsigned CntWidth     = $clog2(DefDepth + 1);

  typedef struct packed {
    logic [DefDataWidth-1:0] data;
    logic [InstrWidth-1:0]   instr;
    logic                    ctrl_flow;
  } id_buf_entry_t;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/id_buf_ptr_wrap.sv
// Combinational modulo-Depth pointer adder: ptr_o = (ptr_i + inc_i) mod Depth.
module id_buf_ptr_wrap
  import id_issue_buffer_pkg::*;
#(
  parameter  int unsigned Depth   = 4,
  parameter  int unsigned NrIssue = 2,
  localparam int unsigned PtrW    = ptr_width(Depth),
  localparam int unsigned IncW    = $clog2(NrIssue + 1)
) (
  input  logic [PtrW-1:0] ptr_i,
  input  logic [IncW-1:0] inc_i,
  output logic [PtrW-1:0] ptr_o
);

  localparam int unsigned SumW = PtrW + 1;

  logic [SumW-1:0] sum;

  // ptr_i < Depth and inc_i <= Depth, so one conditional subtract is enough.
  always_comb begin
    sum = {1'b0, ptr_i} + SumW'(inc_i);
    if (sum >= SumW'(Depth)) sum = sum - SumW'(Depth);
    ptr_o = sum[PtrW-1:0];
  end

endmodule

// File: rtl/id_issue_buffer.sv
// In-order ring buffer between decode and issue, presenting the NrIssue oldest entries.
// Optional control-flow fence: ID_ISSUE_BUFFER_CTRL_FLOW_FENCE_EN.
module id_issue_buffer
  import id_issue_buffer_pkg::*;
#(
  parameter  int unsigned DataWidth = 128,
  parameter  int unsigned Depth     = 4,
  parameter  int unsigned NrIssue   = 2,
  localparam int unsigned PtrW      = ptr_width(Depth),
  localparam int unsigned CntW      = cnt_width(Depth),
  localparam int unsigned AckW      = $clog2(NrIssue + 1)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            flush_i,
  input  logic                            enq_valid_i,
  output logic                            enq_ready_o,
  input  logic [DataWidth-1:0]            enq_data_i,
  input  logic [31:0]                     enq_instr_i,
  input  logic                            enq_ctrl_flow_i,
  output logic [NrIssue-1:0]              deq_valid_o,
  output logic [NrIssue*DataWidth-1:0]    deq_data_o,
  output logic [NrIssue*32-1:0]           deq_instr_o,
  output logic [NrIssue-1:0]              deq_ctrl_flow_o,
  input  logic [NrIssue-1:0]              deq_ack_i,
  output logic [CntW-1:0]                 occupancy_o
);

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [31:0]          instr;
    logic                 ctrl_flow;
  } entry_t;

  entry_t          mem_q [Depth];
  entry_t          slot  [NrIssue];
  entry_t          entry_in;
  logic [PtrW-1:0] slot_addr [NrIssue];
  logic [PtrW-1:0] rd_q, wr_q, rd_nxt, wr_nxt;
  logic [CntW-1:0] count_q, count_d, cnt_after_ack;
  logic [AckW-1:0] n_ack;
  logic            fire;
  logic            fence_block;

  assign entry_in = '{data: enq_data_i, instr: enq_instr_i, ctrl_flow: enq_ctrl_flow_i};

  always_comb begin
    n_ack = '0;
    for (int i = 0; i < NrIssue; i++) n_ack = n_ack + AckW'(deq_ack_i[i]);
  end

  for (genvar i = 0; i < NrIssue; i++) begin : g_slot
    id_buf_ptr_wrap #(.Depth(Depth), .NrIssue(NrIssue)) u_slot_addr (
      .ptr_i (rd_q),
      .inc_i (AckW'(i)),
      .ptr_o (slot_addr[i])
    );
    assign deq_valid_o[i]                        = (count_q > CntW'(i));
    assign slot[i]                               = deq_valid_o[i] ? mem_q[slot_addr[i]] : '0;
    assign deq_data_o[i*DataWidth +: DataWidth]  = slot[i].data;
    assign deq_instr_o[i*32 +: 32]               = slot[i].instr;
    assign deq_ctrl_flow_o[i]                    = slot[i].ctrl_flow;
  end

  id_buf_ptr_wrap #(.Depth(Depth), .NrIssue(NrIssue)) u_rd_wrap (
    .ptr_i (rd_q),
    .inc_i (n_ack),
    .ptr_o (rd_nxt)
  );

  id_buf_ptr_wrap #(.Depth(Depth), .NrIssue(NrIssue)) u_wr_wrap (
    .ptr_i (wr_q),
    .inc_i (AckW'(1)),
    .ptr_o (wr_nxt)
  );

  // Acks free space in the same cycle, so a full buffer can still accept.
  assign cnt_after_ack = count_q - CntW'(n_ack);
  assign enq_ready_o   = rst_ni && !flush_i && (cnt_after_ack < CntW'(Depth)) && !fence_block;
  assign fire          = enq_valid_i && enq_ready_o;
  assign count_d       = flush_i ? '0 : cnt_after_ack + CntW'(fire);
  assign occupancy_o   = count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      if (fire) mem_q[wr_q] <= entry_in;
      if (flush_i) begin
        rd_q <= '0;
        wr_q <= '0;
      end else begin
        rd_q <= rd_nxt;
        if (fire) wr_q <= wr_nxt;
      end
      count_q <= count_d;
    end
  end

`ifdef ID_ISSUE_BUFFER_CTRL_FLOW_FENCE_EN
  // Only one unresolved control-flow entry may be resident at a time.
  logic [CntW-1:0] cf_cnt_q, cf_left, cf_acked;

  always_comb begin
    cf_acked = '0;
    for (int i = 0; i < NrIssue; i++)
      cf_acked = cf_acked + CntW'(deq_ack_i[i] && slot[i].ctrl_flow);
  end

  assign cf_left     = cf_cnt_q - cf_acked;
  assign fence_block = enq_ctrl_flow_i && (cf_left != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      cf_cnt_q <= '0;
    else if (flush_i) cf_cnt_q <= '0;
    else              cf_cnt_q <= cf_left + CntW'(fire && enq_ctrl_flow_i);
  end
`else
  assign fence_block = 1'b0;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert ((deq_ack_i & NrIssue'(deq_ack_i + 1'b1)) == '0)
        else $error("id_issue_buffer: deq_ack_i not a thermometer prefix: %b", deq_ack_i);
      assert ((deq_ack_i & ~deq_valid_o) == '0)
        else $error("id_issue_buffer: ack on invalid slot: ack=%b valid=%b", deq_ack_i, deq_valid_o);
    end
  end
`endif

endmodule

// File: tb/tb_id_issue_buffer.sv
// Directed self-checking bench: Depth=4 instance for the main sequence, Depth=3 instance for wrap.
module tb_id_issue_buffer;

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  // Depth=4, NrIssue=2, DataWidth=128
  logic         a_flush, a_enq_valid, a_enq_ready, a_enq_cf;
  logic [127:0] a_enq_data;
  logic [31:0]  a_enq_instr;
  logic [1:0]   a_deq_valid, a_deq_cf, a_ack;
  logic [255:0] a_deq_data;
  logic [63:0]  a_deq_instr;
  logic [2:0]   a_occ;

  // Depth=3, NrIssue=2, DataWidth=16
  logic         b_flush, b_enq_valid, b_enq_ready, b_enq_cf;
  logic [15:0]  b_enq_data;
  logic [31:0]  b_enq_instr;
  logic [1:0]   b_deq_valid, b_deq_cf, b_ack;
  logic [31:0]  b_deq_data;
  logic [63:0]  b_deq_instr;
  logic [1:0]   b_occ;

  id_issue_buffer #(.DataWidth(128), .Depth(4), .NrIssue(2)) dut4 (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(a_flush),
    .enq_valid_i(a_enq_valid), .enq_ready_o(a_enq_ready), .enq_data_i(a_enq_data),
    .enq_instr_i(a_enq_instr), .enq_ctrl_flow_i(a_enq_cf),
    .deq_valid_o(a_deq_valid), .deq_data_o(a_deq_data), .deq_instr_o(a_deq_instr),
    .deq_ctrl_flow_o(a_deq_cf), .deq_ack_i(a_ack), .occupancy_o(a_occ)
  );

  id_issue_buffer #(.DataWidth(16), .Depth(3), .NrIssue(2)) dut3 (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(b_flush),
    .enq_valid_i(b_enq_valid), .enq_ready_o(b_enq_ready), .enq_data_i(b_enq_data),
    .enq_instr_i(b_enq_instr), .enq_ctrl_flow_i(b_enq_cf),
    .deq_valid_o(b_deq_valid), .deq_data_o(b_deq_data), .deq_instr_o(b_deq_instr),
    .deq_ctrl_flow_o(b_deq_cf), .deq_ack_i(b_ack), .occupancy_o(b_occ)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [127:0] dat4(input int k);
    logic [31:0] w;
    w = 32'hD000_0000 + 32'(k);
    return {w, w, w, w};
  endfunction

  task automatic a_enq(input int k, input logic cf);
    a_enq_valid = 1'b1;
    a_enq_data  = dat4(k);
    a_enq_instr = 32'h1000 + 32'(k);
    a_enq_cf    = cf;
  endtask

  logic [15:0] q[$];
  int          n_exp;
  logic        rdy_exp;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_ni = 1'b0;
    a_flush = 0; a_enq_valid = 0; a_enq_cf = 0; a_enq_data = '0; a_enq_instr = '0; a_ack = '0;
    b_flush = 0; b_enq_valid = 0; b_enq_cf = 0; b_enq_data = '0; b_enq_instr = '0; b_ack = '0;
    #1;
    check("reset_occ",   a_occ, 0);
    check("reset_ready", a_enq_ready, 0);
    check("reset_valid", a_deq_valid, 0);
    tick();
    rst_ni = 1'b1;
    tick();

    // fill to Depth with no acks
    for (int k = 0; k < 4; k++) begin
      a_enq(k, 1'b0);
      #1 check("fill_ready", a_enq_ready, 1);
      tick();
    end
    a_enq_valid = 0;
    #1;
    check("full_occ",    a_occ, 4);
    check("full_ready",  a_enq_ready, 0);
    check("full_valid",  a_deq_valid, 2'b11);
    check("full_slot0",  a_deq_data[127:0], dat4(0));
    check("full_instr1", a_deq_instr[63:32], 32'h1001);

    // full, ack one, enqueue same cycle
    a_ack = 2'b01;
    a_enq(4, 1'b0);
    #1 check("full_ack_ready", a_enq_ready, 1);
    tick();
    a_ack = 2'b00; a_enq_valid = 0;
    #1;
    check("ackenq_occ",   a_occ, 4);
    check("ackenq_slot0", a_deq_data[127:0], dat4(1));
    check("ackenq_slot1", a_deq_data[255:128], dat4(2));

    a_ack = 2'b11;
    tick();
    a_ack = 2'b00;
    #1;
    check("drain_occ",    a_occ, 2);
    check("drain_instr0", a_deq_instr[31:0], 32'h1003);
    check("drain_instr1", a_deq_instr[63:32], 32'h1004);
    a_ack = 2'b11;
    tick();
    a_ack = 2'b00;
    #1;
    check("empty_occ",   a_occ, 0);
    check("empty_valid", a_deq_valid, 0);

    // empty with enqueue: no bypass
    a_enq(5, 1'b0);
    #1;
    check("nobypass_valid", a_deq_valid, 0);
    check("nobypass_ready", a_enq_ready, 1);
    tick();
    a_enq_valid = 0;
    #1;
    check("lat1_valid", a_deq_valid, 2'b01);
    check("lat1_slot0", a_deq_data[127:0], dat4(5));
    check("lat1_slot1", a_deq_data[255:128], 0);

    // flush at occupancy 3 with acks and enqueue
    a_enq(6, 1'b0); tick();
    a_enq(7, 1'b0); tick();
    a_enq_valid = 0;
    #1 check("preflush_occ", a_occ, 3);
    a_flush = 1; a_ack = 2'b11;
    a_enq(8, 1'b0);
    #1;
    check("flush_ready", a_enq_ready, 0);
    check("flush_valid", a_deq_valid, 2'b11);
    tick();
    a_flush = 0; a_ack = 2'b00; a_enq_valid = 0;
    #1;
    check("postflush_occ",   a_occ, 0);
    check("postflush_valid", a_deq_valid, 0);
    check("postflush_data",  a_deq_data, 0);

    a_enq(9, 1'b0);  tick();
    a_enq(10, 1'b0); tick();
    a_enq_valid = 0;
    #1;
    check("refill_occ",    a_occ, 2);
    check("refill_instr0", a_deq_instr[31:0], 32'h1009);

    // asynchronous reset mid-cycle
    a_enq_valid = 1;
    #1 rst_ni = 1'b0;
    #1;
    check("async_occ",   a_occ, 0);
    check("async_valid", a_deq_valid, 0);
    check("async_data",  a_deq_data, 0);
    check("async_instr", a_deq_instr, 0);
    check("async_ready", a_enq_ready, 0);
    a_enq_valid = 0;
    tick();
    rst_ni = 1'b1;
    tick();

    // control-flow fence: A then B
    a_enq(0, 1'b1); a_enq_instr = 32'h2000_0063;
    #1 check("cfA_ready", a_enq_ready, 1);
    tick();
    a_enq_instr = 32'h2001_0063;
`ifdef ID_ISSUE_BUFFER_CTRL_FLOW_FENCE_EN
    #1 check("cfB_ready", a_enq_ready, 0);
    tick();
    #1;
    check("cfB_stall_ready", a_enq_ready, 0);
    check("cfB_stall_occ",   a_occ, 1);
    a_ack = 2'b01;
    #1 check("cfB_ack_ready", a_enq_ready, 1);
    tick();
    a_ack = 2'b00;
    a_enq(1, 1'b0); a_enq_instr = 32'h0000_0013;
    #1 check("cfC_ready", a_enq_ready, 1);
    tick();
    a_enq_valid = 0;
    #1;
    check("cf_occ",    a_occ, 2);
    check("cf_instr0", a_deq_instr[31:0], 32'h2001_0063);
    check("cf_flags",  a_deq_cf, 2'b01);
`else
    #1 check("cfB_ready", a_enq_ready, 1);
    tick();
    a_enq(1, 1'b0); a_enq_instr = 32'h0000_0013;
    #1 check("cfC_ready", a_enq_ready, 1);
    tick();
    a_enq_valid = 0;
    #1;
    check("cf_occ",    a_occ, 3);
    check("cf_instr1", a_deq_instr[63:32], 32'h2001_0063);
    check("cf_flags",  a_deq_cf, 2'b11);
`endif

    // Depth=3 wrap run against a reference FIFO
    for (int k = 0; k < 3; k++) begin
      b_enq_valid = 1; b_enq_data = 16'hA000 + 16'(k);
      tick();
      q.push_back(16'hA000 + 16'(k));
    end
    for (int c = 0; c < 7; c++) begin
      n_exp   = (q.size() >= 2) ? 2 : q.size();
      b_ack   = (n_exp == 2) ? 2'b11 : (n_exp == 1) ? 2'b01 : 2'b00;
      b_enq_valid = 1; b_enq_data = 16'hA010 + 16'(c);
      rdy_exp = (q.size() - n_exp) < 3;
      #1;
      check("wrap_occ",   b_occ, q.size());
      check("wrap_valid", b_deq_valid, {q.size() > 1, q.size() > 0});
      check("wrap_slot0", b_deq_data[15:0],  (q.size() > 0) ? q[0] : 16'h0);
      check("wrap_slot1", b_deq_data[31:16], (q.size() > 1) ? q[1] : 16'h0);
      check("wrap_ready", b_enq_ready, rdy_exp);
      tick();
      for (int p = 0; p < n_exp; p++) void'(q.pop_front());
      if (rdy_exp) q.push_back(16'hA010 + 16'(c));
    end
    b_enq_valid = 0; b_ack = 2'b00;
    #1;
    check("wrap_final_occ",   b_occ, q.size());
    check("wrap_final_slot0", b_deq_data[15:0], (q.size() > 0) ? q[0] : 16'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
